// File: rtl/game_pkg.sv
// Shared types and helpers for the cat-vs-dog game controller.
// State encoding, player identifiers and hit-point arithmetic.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        TURN_CAT   = 3'd1,
        TURN_DOG   = 3'd2,
        FLIGHT_CAT = 3'd3,
        FLIGHT_DOG = 3'd4,
        SETTLE     = 3'd5,
        GAME_OVER  = 3'd6
    } turn_state_t;

    localparam logic PLAYER_CAT = 1'b0;
    localparam logic PLAYER_DOG = 1'b1;

    localparam int HP_W    = 3;
    localparam int TIMER_W = 10;

    // Damage saturates at zero so a large HIT_DAMAGE cannot wrap the HP.
    function automatic logic [HP_W-1:0] hp_after_hit(input logic [HP_W-1:0] hp,
                                                     input logic            hit,
                                                     input int              dmg);
        if (!hit) return hp;
        if (int'(hp) > dmg) return HP_W'(int'(hp) - dmg);
        return '0;
    endfunction

endpackage

// File: rtl/turn_scheduler_if.sv
// Bundle between the turn scheduler and the draw, projectile and HUD blocks.
// master drives game events; slave is the scheduler that returns turn/HUD state.
interface turn_scheduler_if;
    import game_pkg::*;

    logic               frame_tick;
    logic               start;
    logic               cat_throw_complete;
    logic               dog_throw_complete;
    logic               flight_done;
    logic               hit_cat;
    logic               hit_dog;
    logic               cat_turn_active;
    logic               dog_turn_active;
    logic               launch;
    logic               launch_owner;
    logic [HP_W-1:0]    cat_hp;
    logic [HP_W-1:0]    dog_hp;
    logic [TIMER_W-1:0] turn_frames_left;
    logic               game_over;
    logic               winner;
    logic [2:0]         phase;

    modport master (
        output frame_tick, start, cat_throw_complete, dog_throw_complete,
               flight_done, hit_cat, hit_dog,
        input  cat_turn_active, dog_turn_active, launch, launch_owner,
               cat_hp, dog_hp, turn_frames_left, game_over, winner, phase
    );

    modport slave (
        input  frame_tick, start, cat_throw_complete, dog_throw_complete,
               flight_done, hit_cat, hit_dog,
        output cat_turn_active, dog_turn_active, launch, launch_owner,
               cat_hp, dog_hp, turn_frames_left, game_over, winner, phase
    );

endinterface

// File: rtl/turn_scheduler_frame_down_counter.sv
// Loadable frame counter: load wins, otherwise decrements on enabled frame ticks, holding at zero.
// Count is registered; zero flag is a decode of the count.
module frame_down_counter #(
    parameter int W         = 10,
    parameter int RESET_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_tick,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= W'(RESET_VAL);
        end else if (load) begin
            count <= load_val;
        end else if (en && frame_tick && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/turn_scheduler.sv
// Game turn controller: alternates cat/dog turns, launches the projectile, applies hits, picks the winner.
// Every output is registered, reacting one cycle after the triggering input; no backpressure.
module turn_scheduler
    import game_pkg::*;
#(
    parameter int HP_MAX        = 5,
    parameter int HIT_DAMAGE    = 1,
    parameter int TURN_FRAMES   = 600,
    parameter int FLIGHT_FRAMES = 300,
    parameter int SETTLE_FRAMES = 30,
    parameter int FIRST_PLAYER  = 0
) (
    input logic             clk,
    input logic             rst,
    turn_scheduler_if.slave bus
);

    localparam logic            FIRST_IS_DOG = (FIRST_PLAYER != 0);
    localparam logic [HP_W-1:0] HP_INIT      = HP_W'(HP_MAX);

    turn_state_t        state, state_nxt;
    logic               next_player, next_player_nxt;
    logic               owner, owner_nxt;
    logic               winner, winner_nxt;
    logic [HP_W-1:0]    cat_hp, cat_hp_nxt;
    logic [HP_W-1:0]    dog_hp, dog_hp_nxt;
    logic               launch, launch_nxt;
    logic               cat_active, dog_active, game_over;
    logic               cat_prev, dog_prev, cat_edge, dog_edge;
    logic               in_turn, in_flight, in_settle;
    logic               turn_load, flight_load, settle_load;
    logic               turn_zero, flight_zero, settle_zero;
    logic [TIMER_W-1:0] turn_cnt, flight_cnt, settle_cnt;
    logic               unused_cnt;

    assign cat_edge  = bus.cat_throw_complete && !cat_prev;
    assign dog_edge  = bus.dog_throw_complete && !dog_prev;
    assign in_turn   = (state == TURN_CAT) || (state == TURN_DOG);
    assign in_flight = (state == FLIGHT_CAT) || (state == FLIGHT_DOG);
    assign in_settle = (state == SETTLE);

    frame_down_counter #(.W(TIMER_W), .RESET_VAL(TURN_FRAMES)) u_turn_timer (
        .clk(clk), .rst(rst), .frame_tick(bus.frame_tick), .en(in_turn),
        .load(turn_load), .load_val(TIMER_W'(TURN_FRAMES)),
        .count(turn_cnt), .zero(turn_zero)
    );

    frame_down_counter #(.W(TIMER_W), .RESET_VAL(0)) u_flight_timer (
        .clk(clk), .rst(rst), .frame_tick(bus.frame_tick), .en(in_flight),
        .load(flight_load), .load_val(TIMER_W'(FLIGHT_FRAMES)),
        .count(flight_cnt), .zero(flight_zero)
    );

    // Loaded one short so the transition fires on the SETTLE_FRAMES-th tick itself.
    frame_down_counter #(.W(TIMER_W), .RESET_VAL(0)) u_settle_timer (
        .clk(clk), .rst(rst), .frame_tick(bus.frame_tick), .en(in_settle),
        .load(settle_load), .load_val(TIMER_W'(SETTLE_FRAMES - 1)),
        .count(settle_cnt), .zero(settle_zero)
    );

    assign unused_cnt = ^{flight_cnt, settle_cnt};

    always_comb begin
        state_nxt       = state;
        next_player_nxt = next_player;
        owner_nxt       = owner;
        winner_nxt      = winner;
        cat_hp_nxt      = cat_hp;
        dog_hp_nxt      = dog_hp;
        launch_nxt      = 1'b0;
        turn_load       = 1'b0;
        flight_load     = 1'b0;
        settle_load     = 1'b0;

        case (state)
            IDLE, GAME_OVER: begin
                if (bus.start) begin
                    state_nxt  = FIRST_IS_DOG ? TURN_DOG : TURN_CAT;
                    cat_hp_nxt = HP_INIT;
                    dog_hp_nxt = HP_INIT;
                    turn_load  = 1'b1;
                end
            end
            TURN_CAT, TURN_DOG: begin
                // A throw beats a timeout arriving in the same cycle.
                if ((state == TURN_CAT) ? cat_edge : dog_edge) begin
                    state_nxt   = (state == TURN_CAT) ? FLIGHT_CAT : FLIGHT_DOG;
                    owner_nxt   = (state == TURN_CAT) ? PLAYER_CAT : PLAYER_DOG;
                    launch_nxt  = 1'b1;
                    flight_load = 1'b1;
                end else if (bus.frame_tick && turn_zero) begin
                    state_nxt       = SETTLE;
                    next_player_nxt = (state == TURN_CAT) ? PLAYER_DOG : PLAYER_CAT;
                    settle_load     = 1'b1;
                end
            end
            FLIGHT_CAT, FLIGHT_DOG: begin
                if (bus.flight_done) begin
                    cat_hp_nxt = hp_after_hit(cat_hp, bus.hit_cat, HIT_DAMAGE);
                    dog_hp_nxt = hp_after_hit(dog_hp, bus.hit_dog, HIT_DAMAGE);
                    if (cat_hp_nxt == '0 || dog_hp_nxt == '0) begin
                        state_nxt = GAME_OVER;
                        if (cat_hp_nxt == '0 && dog_hp_nxt == '0) winner_nxt = owner;
                        else winner_nxt = (cat_hp_nxt == '0) ? PLAYER_DOG : PLAYER_CAT;
                    end else begin
                        state_nxt       = SETTLE;
                        next_player_nxt = !owner;
                        settle_load     = 1'b1;
                    end
                end else if (bus.frame_tick && flight_zero) begin
                    state_nxt       = SETTLE;
                    next_player_nxt = !owner;
                    settle_load     = 1'b1;
                end
            end
            SETTLE: begin
                if (bus.frame_tick && settle_zero) begin
                    state_nxt = next_player ? TURN_DOG : TURN_CAT;
                    turn_load = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            next_player <= PLAYER_CAT;
            owner       <= PLAYER_CAT;
            winner      <= PLAYER_CAT;
            cat_hp      <= HP_INIT;
            dog_hp      <= HP_INIT;
            launch      <= 1'b0;
            cat_active  <= 1'b0;
            dog_active  <= 1'b0;
            game_over   <= 1'b0;
            cat_prev    <= 1'b0;
            dog_prev    <= 1'b0;
        end else begin
            state       <= state_nxt;
            next_player <= next_player_nxt;
            owner       <= owner_nxt;
            winner      <= winner_nxt;
            cat_hp      <= cat_hp_nxt;
            dog_hp      <= dog_hp_nxt;
            launch      <= launch_nxt;
            cat_active  <= (state_nxt == TURN_CAT);
            dog_active  <= (state_nxt == TURN_DOG);
            game_over   <= (state_nxt == GAME_OVER);
            cat_prev    <= bus.cat_throw_complete;
            dog_prev    <= bus.dog_throw_complete;
        end
    end

    assign bus.cat_turn_active  = cat_active;
    assign bus.dog_turn_active  = dog_active;
    assign bus.launch           = launch;
    assign bus.launch_owner     = owner;
    assign bus.cat_hp           = cat_hp;
    assign bus.dog_hp           = dog_hp;
    assign bus.turn_frames_left = turn_cnt;
    assign bus.game_over        = game_over;
    assign bus.winner           = winner;
    assign bus.phase            = state;

endmodule
